// File: rtl/zddaq_b_axil_arbiter_if.sv
// zddaq_b_axil_arbiter_if: requester ports plus AXI4-Lite master channels; timeout_flag exists only with ZDDAQ_B_AXIL_TIMEOUT_EN
interface zddaq_b_axil_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  r0_req_valid, r0_req_ready, r0_req_wr;
  logic [ADDR_WIDTH-1:0] r0_req_addr;
  logic [DATA_WIDTH-1:0] r0_req_wdata;
  logic [3:0]            r0_req_wstrb;
  logic                  r0_rsp_valid;
  logic [DATA_WIDTH-1:0] r0_rsp_rdata;
  logic [1:0]            r0_rsp_resp;
  logic                  r1_req_valid, r1_req_ready, r1_req_wr;
  logic [ADDR_WIDTH-1:0] r1_req_addr;
  logic [DATA_WIDTH-1:0] r1_req_wdata;
  logic [3:0]            r1_req_wstrb;
  logic                  r1_rsp_valid;
  logic [DATA_WIDTH-1:0] r1_rsp_rdata;
  logic [1:0]            r1_rsp_resp;
  logic [ADDR_WIDTH-1:0] M_AXI_AWADDR, M_AXI_ARADDR;
  logic [2:0]            M_AXI_AWPROT, M_AXI_ARPROT;
  logic                  M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic [DATA_WIDTH-1:0] M_AXI_WDATA, M_AXI_RDATA;
  logic [3:0]            M_AXI_WSTRB;
  logic [1:0]            M_AXI_BRESP, M_AXI_RRESP;
  logic                  M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic                  M_AXI_RVALID, M_AXI_RREADY;
`ifdef ZDDAQ_B_AXIL_TIMEOUT_EN
  logic                  timeout_flag;
`endif

  modport master (
    input  r0_req_valid, r0_req_wr, r0_req_addr, r0_req_wdata, r0_req_wstrb,
    output r0_req_ready, r0_rsp_valid, r0_rsp_rdata, r0_rsp_resp,
    input  r1_req_valid, r1_req_wr, r1_req_addr, r1_req_wdata, r1_req_wstrb,
    output r1_req_ready, r1_rsp_valid, r1_rsp_rdata, r1_rsp_resp,
    output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    output M_AXI_BREADY, M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID, M_AXI_RREADY,
    input  M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID,
    input  M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID
`ifdef ZDDAQ_B_AXIL_TIMEOUT_EN
    , output timeout_flag
`endif
  );

  modport slave (
    output r0_req_valid, r0_req_wr, r0_req_addr, r0_req_wdata, r0_req_wstrb,
    input  r0_req_ready, r0_rsp_valid, r0_rsp_rdata, r0_rsp_resp,
    output r1_req_valid, r1_req_wr, r1_req_addr, r1_req_wdata, r1_req_wstrb,
    input  r1_req_ready, r1_rsp_valid, r1_rsp_rdata, r1_rsp_resp,
    input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    input  M_AXI_BREADY, M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID, M_AXI_RREADY,
    output M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID,
    output M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID
`ifdef ZDDAQ_B_AXIL_TIMEOUT_EN
    , input timeout_flag
`endif
  );
endinterface

// File: rtl/zddaq_b_axil_arbiter.sv
// zddaq_b_axil_arbiter: round-robin two-requester AXI4-Lite master; define ZDDAQ_B_AXIL_TIMEOUT_EN for the SLVERR watchdog
module zddaq_b_axil_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
`ifdef ZDDAQ_B_AXIL_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input logic ACLK,
  input logic ARESETN,
  zddaq_b_axil_arbiter_if.master bus
);
  typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R, DONE} state_t;
  state_t                state_q, state_d;
  logic                  last_grant_q, last_grant_d, owner_q, owner_d;
  logic                  awvalid_q, awvalid_d, wvalid_q, wvalid_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic [1:0]            resp_q, resp_d;
  logic                  grant, sel, sel_wr, tmo;

  assign sel    = bus.r1_req_valid & (~bus.r0_req_valid | ~last_grant_q);
  assign grant  = ARESETN & (state_q == IDLE) & (bus.r0_req_valid | bus.r1_req_valid);
  assign sel_wr = sel ? bus.r1_req_wr : bus.r0_req_wr;

`ifdef ZDDAQ_B_AXIL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;
  logic          busy, flag_q;
  assign busy             = state_q inside {WR_AW_W, WR_B, RD_AR, RD_R};
  assign tmo              = busy & (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign bus.timeout_flag = flag_q;
  // watchdog restarts each transaction; the flag is sticky until reset
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= busy ? cnt_q + 1'b1 : '0;
      flag_q <= flag_q | tmo;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  // next state: grant in IDLE, track AW/W handshakes independently, capture the response
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    rdata_d      = rdata_q;
    resp_d       = resp_q;
    awvalid_d    = awvalid_q & ~bus.M_AXI_AWREADY;
    wvalid_d     = wvalid_q & ~bus.M_AXI_WREADY;
    case (state_q)
      IDLE: if (grant) begin
        last_grant_d = sel;
        owner_d      = sel;
        addr_d       = (sel ? bus.r1_req_addr : bus.r0_req_addr) & ~ADDR_WIDTH'(3);
        wdata_d      = sel ? bus.r1_req_wdata : bus.r0_req_wdata;
        wstrb_d      = sel ? bus.r1_req_wstrb : bus.r0_req_wstrb;
        awvalid_d    = sel_wr;
        wvalid_d     = sel_wr;
        state_d      = sel_wr ? WR_AW_W : RD_AR;
      end
      WR_AW_W: state_d = (awvalid_d | wvalid_d) ? WR_AW_W : WR_B;
      WR_B: if (bus.M_AXI_BVALID) begin
        resp_d  = bus.M_AXI_BRESP;
        rdata_d = '0;
        state_d = DONE;
      end
      RD_AR: state_d = bus.M_AXI_ARREADY ? RD_R : RD_AR;
      RD_R: if (bus.M_AXI_RVALID) begin
        resp_d  = bus.M_AXI_RRESP;
        rdata_d = bus.M_AXI_RDATA;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    if (tmo) begin
      state_d   = DONE;
      awvalid_d = 1'b0;
      wvalid_d  = 1'b0;
      rdata_d   = '0;
      resp_d    = 2'b10;
    end
  end

  // state register; reset abandons any transaction in flight
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      rdata_q      <= '0;
      resp_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      rdata_q      <= rdata_d;
      resp_q       <= resp_d;
    end
  end

  assign bus.r0_req_ready  = grant & ~sel;
  assign bus.r1_req_ready  = grant & sel;
  assign bus.r0_rsp_valid  = (state_q == DONE) & ~owner_q;
  assign bus.r1_rsp_valid  = (state_q == DONE) & owner_q;
  assign bus.r0_rsp_rdata  = rdata_q;
  assign bus.r1_rsp_rdata  = rdata_q;
  assign bus.r0_rsp_resp   = resp_q;
  assign bus.r1_rsp_resp   = resp_q;
  assign bus.M_AXI_AWADDR  = addr_q;
  assign bus.M_AXI_ARADDR  = addr_q;
  assign bus.M_AXI_AWPROT  = 3'b000;
  assign bus.M_AXI_ARPROT  = 3'b000;
  assign bus.M_AXI_AWVALID = awvalid_q;
  assign bus.M_AXI_WVALID  = wvalid_q;
  assign bus.M_AXI_WDATA   = wdata_q;
  assign bus.M_AXI_WSTRB   = wstrb_q;
  assign bus.M_AXI_BREADY  = state_q == WR_B;
  assign bus.M_AXI_ARVALID = state_q == RD_AR;
  assign bus.M_AXI_RREADY  = state_q == RD_R;
endmodule

// File: tb/tb_zddaq_b_axil_arbiter.sv
// tb_zddaq_b_axil_arbiter: scoreboard bench with a reactive AXI4-Lite slave model
`timescale 1ns/1ps
module tb_zddaq_b_axil_arbiter;
`ifdef ZDDAQ_B_AXIL_TIMEOUT_EN
  localparam int TMO = 16;
`endif
  logic clk = 1'b0, rstn = 1'b0;
  always #5 clk = ~clk;

  zddaq_b_axil_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
  zddaq_b_axil_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32)
`ifdef ZDDAQ_B_AXIL_TIMEOUT_EN
    , .TIMEOUT_CYCLES(TMO)
`endif
  ) dut (.ACLK(clk), .ARESETN(rstn), .bus(bus));

  typedef struct packed { logic own; logic [31:0] rdata; logic [1:0] resp; } exp_t;
  exp_t        sb[$];
  int          grant_log[$], acc_log[$];
  logic [31:0] model [16], mem [16];
  logic [31:0] err_addr = 32'hC;
  int          checks = 0, fails = 0;
  int          cyc = 0, acc_cyc = 0, rsp_cnt = 0, rsp_cyc = 0;
  int          acc_cnt [2];
  int          aw_first = -1, w_first = -1, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  logic [31:0] last_araddr = '0;
  bit          tmo_mode = 0, aw_block = 0, r_stall = 0;
  int          aw_hold = 1;
  bit          aw_got = 0, w_got = 0, b_pend = 0, r_pend = 0;
  int          aw_wait = 0;
  logic [31:0] aw_a = '0, w_d = '0, ar_a = '0;
  logic [3:0]  w_s = '0;

  task automatic chk(string tag, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic void accept(bit n, bit wr, logic [31:0] a, logic [31:0] d, logic [3:0] s);
    exp_t e;
    e.own = n;
    if (wr) begin
      if (!tmo_mode)
        for (int b = 0; b < 4; b++) if (s[b]) model[a[5:2]][8*b +: 8] = d[8*b +: 8];
      e.rdata = '0;
      e.resp  = tmo_mode ? 2'b10 : 2'b00;
    end else begin
      e.rdata = tmo_mode ? '0 : model[a[5:2]];
      e.resp  = (tmo_mode || {a[31:2], 2'b00} == err_addr) ? 2'b10 : 2'b00;
    end
    sb.push_back(e);
    acc_cnt[n]++;
    acc_cyc = cyc;
    grant_log.push_back(int'(n));
    acc_log.push_back(cyc);
  endfunction

  initial for (int i = 0; i < 16; i++) begin
    model[i] = 32'hA5000000 | i;
    mem[i]   = 32'hA5000000 | i;
  end

  // accept monitor and slave bookkeeping, both on pre-edge values
  always @(posedge clk) begin
    if (!rstn) begin
      sb.delete();
      aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0; aw_wait = 0;
    end else begin
      if (bus.r0_req_valid && bus.r0_req_ready)
        accept(0, bus.r0_req_wr, bus.r0_req_addr, bus.r0_req_wdata, bus.r0_req_wstrb);
      if (bus.r1_req_valid && bus.r1_req_ready)
        accept(1, bus.r1_req_wr, bus.r1_req_addr, bus.r1_req_wdata, bus.r1_req_wstrb);
      if (bus.M_AXI_BVALID && bus.M_AXI_BREADY) b_pend = 0;
      if (bus.M_AXI_RVALID && bus.M_AXI_RREADY) r_pend = 0;
      if (bus.M_AXI_AWVALID && bus.M_AXI_AWREADY) begin
        aw_got = 1; aw_a = bus.M_AXI_AWADDR; aw_wait = 0;
      end else if (bus.M_AXI_AWVALID) aw_wait++;
      if (bus.M_AXI_WVALID && bus.M_AXI_WREADY) begin
        w_got = 1; w_d = bus.M_AXI_WDATA; w_s = bus.M_AXI_WSTRB;
      end
      if (aw_got && w_got) begin
        for (int b = 0; b < 4; b++) if (w_s[b]) mem[aw_a[5:2]][8*b +: 8] = w_d[8*b +: 8];
        aw_got = 0; w_got = 0; b_pend = 1;
      end
      if (bus.M_AXI_ARVALID && bus.M_AXI_ARREADY) begin
        r_pend = 1; ar_a = bus.M_AXI_ARADDR;
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    bus.M_AXI_AWREADY = !aw_block && (aw_wait >= aw_hold - 1);
    bus.M_AXI_WREADY  = 1'b1;
    bus.M_AXI_ARREADY = 1'b1;
    bus.M_AXI_BVALID  = b_pend;
    bus.M_AXI_BRESP   = 2'b00;
    bus.M_AXI_RVALID  = r_pend && !r_stall;
    bus.M_AXI_RDATA   = mem[ar_a[5:2]];
    bus.M_AXI_RRESP   = (ar_a == err_addr) ? 2'b10 : 2'b00;
  end

  // response scoreboard and channel activity counters
  always @(negedge clk) begin
    exp_t e;
    if (bus.M_AXI_AWVALID) begin aw_cnt++; if (aw_first < 0) aw_first = cyc; end
    if (bus.M_AXI_WVALID) begin w_cnt++; if (w_first < 0) w_first = cyc; end
    if (bus.M_AXI_BREADY) b_cnt++;
    if (bus.M_AXI_ARVALID) last_araddr = bus.M_AXI_ARADDR;
    if (bus.r0_rsp_valid || bus.r1_rsp_valid) begin
      rsp_cnt++;
      rsp_cyc = cyc;
      chk("rsp_onehot", 64'(bus.r0_rsp_valid & bus.r1_rsp_valid), 64'd0);
      if (sb.size() == 0) chk("rsp_unexpected", 64'd1, 64'd0);
      else begin
        e = sb.pop_front();
        chk("rsp_owner", 64'(bus.r1_rsp_valid), 64'(e.own));
        chk("rsp_rdata", 64'(e.own ? bus.r1_rsp_rdata : bus.r0_rsp_rdata), 64'(e.rdata));
        chk("rsp_resp", 64'(e.own ? bus.r1_rsp_resp : bus.r0_rsp_resp), 64'(e.resp));
      end
    end
  end

  task automatic issue(input bit n, input bit wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    int c0 = acc_cnt[n];
    if (n) begin
      bus.r1_req_wr = wr; bus.r1_req_addr = a; bus.r1_req_wdata = d; bus.r1_req_wstrb = s;
      bus.r1_req_valid = 1'b1;
    end else begin
      bus.r0_req_wr = wr; bus.r0_req_addr = a; bus.r0_req_wdata = d; bus.r0_req_wstrb = s;
      bus.r0_req_valid = 1'b1;
    end
    for (int i = 0; i < 200 && acc_cnt[n] == c0; i++) @(negedge clk);
    chk("accepted", 64'(acc_cnt[n] != c0), 64'd1);
    if (n) bus.r1_req_valid = 1'b0;
    else bus.r0_req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    chk("drain", 64'(sb.size()), 64'd0);
    @(negedge clk);
  endtask

  task automatic chk_quiet(string tag);
    chk({tag, "_ctl"}, 64'({bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY, bus.M_AXI_ARVALID,
                            bus.M_AXI_RREADY, bus.r0_rsp_valid, bus.r1_rsp_valid}), 64'd0);
    chk({tag, "_addr"}, 64'({bus.M_AXI_AWADDR, bus.M_AXI_ARADDR}), 64'd0);
    chk({tag, "_wdata"}, 64'({bus.M_AXI_WDATA, bus.M_AXI_WSTRB}), 64'd0);
    chk({tag, "_rsp"}, 64'({bus.r0_rsp_rdata, bus.r0_rsp_resp}), 64'd0);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int rc;
    acc_cnt[0] = 0; acc_cnt[1] = 0;
    bus.r0_req_valid = 0; bus.r0_req_wr = 0; bus.r0_req_addr = 0; bus.r0_req_wdata = 0; bus.r0_req_wstrb = 0;
    bus.r1_req_valid = 0; bus.r1_req_wr = 0; bus.r1_req_addr = 0; bus.r1_req_wdata = 0; bus.r1_req_wstrb = 0;
    repeat (3) @(negedge clk);
    chk_quiet("reset");
    rstn = 1'b1;
    @(negedge clk);

    aw_first = -1; w_first = -1;
    issue(0, 1, 32'h0, 32'h1, 4'hF);
    drain();
    chk("wr_aw_lat", 64'(aw_first - acc_cyc), 64'd1);
    chk("wr_w_lat", 64'(w_first - acc_cyc), 64'd1);
    chk("wr_rsp_lat", 64'(rsp_cyc - acc_cyc), 64'd3);
    issue(0, 0, 32'h0, 32'h0, 4'h0);
    drain();

    do_reset();
    grant_log.delete(); acc_log.delete();
    fork
      issue(0, 0, 32'h4, 32'h0, 4'h0);
      issue(1, 1, 32'h8, 32'h3, 4'hF);
    join
    drain();
    chk("tie1_grants", 64'(grant_log.size()), 64'd2);
    chk("tie1_first", 64'(grant_log[0]), 64'd0);
    chk("tie1_second", 64'(grant_log[1]), 64'd1);
    chk("tie_gap", 64'(acc_log[1] - acc_log[0]), 64'd4);
    fork
      issue(0, 0, 32'h8, 32'h0, 4'h0);
      issue(1, 0, 32'h4, 32'h0, 4'h0);
    join
    drain();
    chk("tie2_first", 64'(grant_log[2]), 64'd0);

    aw_hold = 3; aw_cnt = 0; w_cnt = 0; b_cnt = 0; rc = rsp_cnt;
    issue(1, 1, 32'h10, 32'hDEADBEEF, 4'h3);
    drain();
    aw_hold = 1;
    chk("hold_aw_cycles", 64'(aw_cnt), 64'd3);
    chk("hold_w_cycles", 64'(w_cnt), 64'd1);
    chk("hold_b_cycles", 64'(b_cnt), 64'd1);
    chk("hold_rsp_pulses", 64'(rsp_cnt - rc), 64'd1);

    issue(1, 0, 32'hE, 32'h0, 4'h0);
    drain();
    chk("araddr_align", 64'(last_araddr), 64'hC);

    r_stall = 1;
    issue(0, 0, 32'h4, 32'h0, 4'h0);
    for (int i = 0; i < 50 && !bus.M_AXI_RREADY; i++) @(negedge clk);
    chk("reach_rd_r", 64'(bus.M_AXI_RREADY), 64'd1);
    rc = rsp_cnt;
    rstn = 1'b0;
    @(negedge clk);
    chk_quiet("midreset");
    r_stall = 0;
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    chk("abandon_no_rsp", 64'(rsp_cnt - rc), 64'd0);
    issue(0, 0, 32'h10, 32'h0, 4'h0);
    drain();
    chk("post_reset_rsp", 64'(rsp_cnt - rc), 64'd1);

`ifdef ZDDAQ_B_AXIL_TIMEOUT_EN
    chk("tmo_flag_clear", 64'(bus.timeout_flag), 64'd0);
    tmo_mode = 1; aw_block = 1; aw_cnt = 0;
    issue(0, 1, 32'h20, 32'h55, 4'hF);
    drain();
    chk("tmo_aw_cycles", 64'(aw_cnt), 64'(TMO));
    chk("tmo_flag", 64'(bus.timeout_flag), 64'd1);
    chk("tmo_quiet", 64'({bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY}), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/zddaq_b_axil_arbiter.md
Name: zddaq_b_axil_arbiter

Overview:
Two-requester AXI4-Lite master arbiter sharing one AXI4-Lite register port (e.g. the zddaq_b_system_ctrl S00_AXI slave) between a local command sequencer and a host bridge. It accepts single-beat read/write requests on simple valid/ready ports and arbitrates round-robin. It runs exactly one AXI4-Lite transaction at a time and returns the response to the owning requester as a one-cycle pulse.

Parameters:
ADDR_WIDTH, 32, AXI4-Lite address width.
DATA_WIDTH, 32, AXI4-Lite data width; only 32 is supported.
TIMEOUT_CYCLES, 1024, watchdog limit in ACLK cycles; used only with ZDDAQ_B_AXIL_TIMEOUT_EN.

Ports:
ACLK  in  1  clock.
ARESETN  in  1  reset; synchronous, active-low.
rN_req_valid  in  1  request valid, N=0,1.
rN_req_ready  out  1  one-cycle accept pulse.
rN_req_wr  in  1  1=write, 0=read.
rN_req_addr  in  ADDR_WIDTH  byte address.
rN_req_wdata  in  32  write data.
rN_req_wstrb  in  4  write strobes.
rN_rsp_valid  out  1  one-cycle response pulse; no backpressure.
rN_rsp_rdata  out  32  read data; 0 for writes.
rN_rsp_resp  out  2  BRESP/RRESP.
M_AXI_AWADDR/AWPROT/AWVALID  out  ADDR_WIDTH/3/1  write address channel; AWREADY in 1.
M_AXI_WDATA/WSTRB/WVALID  out  32/4/1  write data channel; WREADY in 1.
M_AXI_BRESP/BVALID  in  2/1  write response; BREADY out 1.
M_AXI_ARADDR/ARPROT/ARVALID  out  ADDR_WIDTH/3/1  read address channel; ARREADY in 1.
M_AXI_RDATA/RRESP/RVALID  in  32/2/1  read data; RREADY out 1.

Behaviour:
- Reset is synchronous on ARESETN=0 at the ACLK edge.
  - All valids, readies and rsp pulses go to 0; all data/addr/resp outputs go to 0.
  - FSM goes to IDLE; last_grant=1, so r0 wins the first tie.
- Reset mid-transaction abandons it: no rsp pulse, channels drop on that edge.
- FSM states: IDLE, WR_AW_W, WR_B, RD_AR, RD_R, DONE.
- IDLE:
  - If exactly one rN_req_valid is high, grant that requester.
  - If both are high, grant the one that is not last_grant.
  - On grant, rN_req_ready=1 for that cycle; addr/wdata/wstrb/wr are latched, last_grant updated.
  - Next state is WR_AW_W if wr=1, else RD_AR.
  - Requests are never accepted outside IDLE.
- WR_AW_W:
  - AWVALID and WVALID assert together the cycle after accept.
  - Each drops independently after its own handshake (valid&ready at the edge).
  - Go to WR_B once both have completed, including same-cycle completion.
- WR_B: BREADY=1. On BVALID, capture BRESP, set rdata=0, go to DONE.
- RD_AR: ARVALID=1 until ARREADY, then RD_R.
- RD_R: RREADY=1. On RVALID, capture RDATA/RRESP, go to DONE.
- DONE:
  - rN_rsp_valid=1 for the owner for exactly one cycle; rdata/resp held valid that cycle.
  - Go to IDLE.
  - rsp_rdata/rsp_resp hold their last value until the next DONE.
- AWADDR/ARADDR are output with bits [1:0] forced to 0. AWPROT/ARPROT = 3'b000.
- Zero-wait slave, write accepted at cycle N:
  - AW/W valid at N+1, WR_B at N+2, B handshake at N+2.
  - rsp_valid at N+3; next accept possible at N+4.
- A read has the same timing.
- AXI valids never drop before their handshake, except on reset or timeout.
- BREADY/RREADY are high only in WR_B/RD_R; unexpected BVALID/RVALID in other states is ignored.
- A requester holding rN_req_valid high after its rsp can be granted again only if the other requester is idle; this is fairness by alternation.

Optional Feature:
ZDDAQ_B_AXIL_TIMEOUT_EN
- Defined:
  - A cycle counter clears on IDLE exit and increments in WR_AW_W/WR_B/RD_AR/RD_R.
  - When it reaches TIMEOUT_CYCLES, all M_AXI valids/readies drop on the next edge and the FSM goes to DONE with rsp_resp=2'b10 (SLVERR) and rsp_rdata=0.
  - Sticky output timeout_flag (1 bit) is set; it is cleared only by reset.
- Not defined: no counter, no timeout_flag port, and the FSM waits indefinitely.

Test Plan:
- Write: r0 writes addr 0x0, data 0x00000001, wstrb 0xF, zero-wait slave -> AW/W at N+1, r0_rsp_valid at N+3 with resp 0; readback of 0x0 returns 0x00000001.
- Simultaneous requests after reset: r0 reads 0x4 and r1 writes 0x8=0x3 -> r0 granted first, then r1; a second tie grants r0 again because last_grant=r1.
- Handshake ordering: AWREADY delayed 3 cycles, WREADY immediate -> WVALID drops after 1 cycle, AWVALID held 3 cycles, a single BREADY phase, exactly one rsp pulse.
- Address alignment: read addr 0x0000000E -> ARADDR=0x0000000C; slave RRESP=2'b10 -> r1_rsp_resp=2'b10.
- Reset mid-operation: ARESETN=0 during RD_R -> no rsp pulse, all outputs 0 next edge; the next r0 request is accepted normally.
- Timeout (macro on, TIMEOUT_CYCLES=16): slave never asserts AWREADY -> valids drop at cycle 16, rsp_resp=2'b10, timeout_flag=1.
